pwm_generator: RTL and testbench

//  Tick-driven PWM core that consumes the single-cycle 'ena' strobe from the prescaler.
//  - The period counter advances only on 'ena'.
//  - pwm_out is compared against a double-buffered duty/period pair.
//  - New duty/period values are accepted through a load/ack handshake.
//  - Staged values are applied only at a period boundary, so no glitches or runt pulses are produced.

---
 rtl/pwm_generator.sv | 91 +++++++++
 tb/tb_pwm_generator.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// pwm_generator: tick-driven PWM core with double-buffered duty/period.
// Staged values reach the comparator only at a period wrap.
module pwm_generator #(
  parameter int WIDTH       = 8,
  parameter int INIT_PERIOD = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic [WIDTH-1:0] i_duty_in,
  input  logic [WIDTH-1:0] i_period_in,
  input  logic             i_load,
  output logic             o_pending,
  output logic             o_ack,
  output logic             o_period_start,
  output logic             o_pwm_out
);

  localparam logic [WIDTH-1:0] LP_INIT = WIDTH'(INIT_PERIOD);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty_act;
  logic [WIDTH-1:0] r_period_act;
  logic [WIDTH-1:0] r_duty_stg;
  logic [WIDTH-1:0] r_period_stg;
  logic             r_pending;
  logic             r_ack;
  logic             r_period_start;
  logic             r_pwm;
  logic             w_wrap;

  // '>=' lets the counter recover if it ever sits above the period
  assign w_wrap = i_ena && (r_cnt >= r_period_act);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      r_cnt <= w_wrap ? '0 : r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_duty_act   <= '0;
      r_period_act <= LP_INIT;
    end else if (w_wrap && r_pending) begin
      r_duty_act   <= r_duty_stg;
      r_period_act <= r_period_stg;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_duty_stg   <= '0;
      r_period_stg <= '0;
    end else if (i_load) begin
      r_duty_stg   <= i_duty_in;
      r_period_stg <= i_period_in;
    end
  end

  // a load coinciding with a wrap keeps the new values pending
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 1'b0;
    end else if (i_load) begin
      r_pending <= 1'b1;
    end else if (w_wrap) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack          <= 1'b0;
      r_period_start <= 1'b0;
      r_pwm          <= 1'b0;
    end else begin
      r_ack          <= w_wrap && r_pending;
      r_period_start <= w_wrap;
      r_pwm          <= (r_cnt < r_duty_act);
    end
  end

  assign o_pending      = r_pending;
  assign o_ack          = r_ack;
  assign o_period_start = r_period_start;
  assign o_pwm_out      = r_pwm;

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: scenario tasks plus random traffic against a
// tick-level reference model of the PWM core (WIDTH=4).
module tb_pwm_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [3:0] duty_in = '0;
  logic [3:0] period_in = '0;
  logic       load = 1'b0;
  logic       o_pending;
  logic       o_ack;
  logic       o_period_start;
  logic       o_pwm_out;

  pwm_generator #(.WIDTH(4), .INIT_PERIOD(15)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_ena          (ena),
    .i_duty_in      (duty_in),
    .i_period_in    (period_in),
    .i_load         (load),
    .o_pending      (o_pending),
    .o_ack          (o_ack),
    .o_period_start (o_period_start),
    .o_pwm_out      (o_pwm_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model: position in period, active settings, staged request
  int         m_pos;
  int         m_duty;
  int         m_per;
  logic [7:0] m_q[$];
  bit         e_pend, e_ack, e_ps, e_pwm;
  logic [3:0] bad_got, bad_exp;
  int         bad_cyc;

  function automatic logic [3:0] got();
    return {o_pending, o_ack, o_period_start, o_pwm_out};
  endfunction

  function automatic logic [3:0] expv();
    return {e_pend, e_ack, e_ps, e_pwm};
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_duty = 0;
    m_per = 15;
    m_q.delete();
    {e_pend, e_ack, e_ps, e_pwm} = '0;
  endtask

  // one clock: drive inputs, advance the model, sample 1ns after the edge
  task automatic step(input bit e, input bit ld,
                      input logic [3:0] d, input logic [3:0] p);
    logic [7:0] s;
    ena = e;
    load = ld;
    duty_in = d;
    period_in = p;
    @(posedge clk);
    e_pwm = (m_pos < m_duty);
    e_ack = 1'b0;
    e_ps = 1'b0;
    if (e) begin
      if (m_pos + 1 >= m_per + 1) begin
        m_pos = 0;
        e_ps = 1'b1;
        if (m_q.size() != 0) begin
          s = m_q.pop_front();
          m_duty = int'(s[7:4]);
          m_per = int'(s[3:0]);
          e_ack = 1'b1;
        end
      end else begin
        m_pos = (m_pos + 1) % 16;
      end
    end
    if (ld) begin
      m_q.delete();
      m_q.push_back({d, p});
    end
    e_pend = (m_q.size() != 0);
    cyc++;
    #1;
  endtask

  task automatic note_bad(inout int bad);
    if (got() !== expv()) begin
      if (bad == 0) begin
        bad_got = got();
        bad_exp = expv();
        bad_cyc = cyc;
      end
      bad++;
    end
  endtask

  task automatic run(input int n, input int m, output int bad,
                     output int hi, output int ps,
                     output int acks, output int enas);
    bit e;
    bad = 0; hi = 0; ps = 0; acks = 0; enas = 0;
    for (int k = 0; k < n; k++) begin
      e = (cyc % m == 0);
      enas += int'(e);
      step(e, 1'b0, 4'd0, 4'd0);
      note_bad(bad);
      hi += int'(o_pwm_out);
      ps += int'(o_period_start);
      acks += int'(o_ack);
    end
  endtask

  task automatic run_to_ack(input int m, output int cycles,
                            output int bad, output int hi,
                            output int pdrop);
    bit done;
    done = 0; cycles = 0; bad = 0; hi = 0; pdrop = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      step(cyc % m == 0, 1'b0, 4'd0, 4'd0);
      cycles++;
      note_bad(bad);
      hi += int'(o_pwm_out);
      if (o_ack) done = 1;
      else if (!o_pending) pdrop++;
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset();
    int bad, hi, ps, acks, enas, cy, pd;
    #12;
    n_checks++;
    if (got() !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_init got=%b exp=0000", got());
    end
    rst = 1'b0;
    model_reset();
    run(5, 1, bad, hi, ps, acks, enas);
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL reset_run cyc=%0d got=%b exp=%b", bad_cyc, bad_got, bad_exp);
    end
    step(1'b1, 1'b1, 4'd5, 4'd9);
    run_to_ack(1, cy, bad, hi, pd);
    n_checks++;
    if (cy != 10 || bad != 0) begin
      n_errors++;
      $display("FAIL reset_ack cycles=%0d exp=10 bad=%0d", cy, bad);
    end
    run(3, 1, bad, hi, ps, acks, enas);
    n_checks++;
    if (o_pwm_out !== 1'b1 || bad != 0) begin
      n_errors++;
      $display("FAIL reset_prehigh pwm=%b exp=1 bad=%0d", o_pwm_out, bad);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (got() !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_async got=%b exp=0000", got());
    end
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    run(15, 1, bad, hi, ps, acks, enas);
    n_checks++;
    if (ps != 0 || hi != 0 || bad != 0) begin
      n_errors++;
      $display("FAIL reset_cnt0 ps=%0d hi=%0d exp=0/0 bad=%0d", ps, hi, bad);
    end
    step(1'b1, 1'b0, 4'd0, 4'd0);
    n_checks++;
    if (o_period_start !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_wrap16 ps=%b exp=1", o_period_start);
    end
  endtask

  task automatic test_periodic();
    int bad, hi, cy, pd;
    step(cyc % 4 == 0, 1'b1, 4'd3, 4'd9);
    run_to_ack(4, cy, bad, hi, pd);
    n_checks++;
    if (cy < 0 || bad != 0 || pd != 0) begin
      n_errors++;
      $display("FAIL periodic_ack cycles=%0d bad=%0d pdrop=%0d", cy, bad, pd);
    end
    for (int r = 0; r < 2; r++) begin
      int gap, h;
      bit seen;
      gap = 0; h = 0; seen = 0; bad = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
        step(cyc % 4 == 0, 1'b0, 4'd0, 4'd0);
        note_bad(bad);
        gap++;
        h += int'(o_pwm_out);
        if (o_period_start) seen = 1;
      end
      n_checks++;
      if (gap != 40 || h != 12 || bad != 0) begin
        n_errors++;
        $display("FAIL periodic_shape gap=%0d hi=%0d exp=40/12 bad=%0d", gap, h, bad);
      end
    end
  endtask

  task automatic test_extremes();
    int bad, hi, ps, acks, enas, cy, pd;
    logic [3:0] duties [3];
    int want [3];
    duties[0] = 4'd0;  want[0] = 0;
    duties[1] = 4'd10; want[1] = 30;
    duties[2] = 4'd15; want[2] = 30;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, duties[i], 4'd9);
      run_to_ack(1, cy, bad, hi, pd);
      run(30, 1, bad, hi, ps, acks, enas);
      n_checks++;
      if (cy < 0 || hi != want[i] || bad != 0) begin
        n_errors++;
        $display("FAIL extreme_duty%0d hi=%0d exp=%0d cycles=%0d bad=%0d",
                 duties[i], hi, want[i], cy, bad);
      end
    end
    step(1'b1, 1'b1, 4'd1, 4'd0);
    run_to_ack(2, cy, bad, hi, pd);
    run(20, 2, bad, hi, ps, acks, enas);
    n_checks++;
    if (cy < 0 || hi != 20 || ps != enas || ps != 10 || bad != 0) begin
      n_errors++;
      $display("FAIL extreme_per0 hi=%0d ps=%0d enas=%0d exp=20/10/10 bad=%0d",
               hi, ps, enas, bad);
    end
  endtask

  task automatic test_back_to_back();
    int bad, hi, ps, acks, enas, cy, pd;
    step(1'b1, 1'b1, 4'd5, 4'd9);
    run_to_ack(1, cy, bad, hi, pd);
    run(3, 1, bad, hi, ps, acks, enas);
    step(1'b1, 1'b1, 4'd2, 4'd9);
    n_checks++;
    if (o_pending !== 1'b1 || o_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_first pending=%b ack=%b exp=1/0", o_pending, o_ack);
    end
    step(1'b1, 1'b1, 4'd7, 4'd9);
    run_to_ack(1, cy, bad, hi, pd);
    n_checks++;
    if (cy < 0 || pd != 0 || bad != 0) begin
      n_errors++;
      $display("FAIL b2b_ack cycles=%0d pdrop=%0d bad=%0d", cy, pd, bad);
    end
    run(10, 1, bad, hi, ps, acks, enas);
    n_checks++;
    if (acks != 0 || hi != 7 || ps != 1 || bad != 0) begin
      n_errors++;
      $display("FAIL b2b_single acks=%0d hi=%0d ps=%0d exp=0/7/1 bad=%0d",
               acks, hi, ps, bad);
    end
  endtask

  task automatic test_boundary_load();
    int bad, hi, cy, pd;
    bit hit;
    step(1'b1, 1'b1, 4'd2, 4'd9);
    hit = 0; bad = 0;
    for (int k = 0; k < 30 && !hit; k++) begin
      if (m_pos == 9) begin
        step(1'b1, 1'b1, 4'd4, 4'd9);
        hit = 1;
      end else begin
        step(1'b1, 1'b0, 4'd0, 4'd0);
        note_bad(bad);
      end
    end
    n_checks++;
    if (!hit || o_ack !== 1'b1 || o_pending !== 1'b1 || bad != 0) begin
      n_errors++;
      $display("FAIL bnd_load ack=%b pending=%b exp=1/1 hit=%0d bad=%0d",
               o_ack, o_pending, hit, bad);
    end
    run_to_ack(1, cy, bad, hi, pd);
    n_checks++;
    if (cy != 10 || hi != 2 || pd != 0 || bad != 0) begin
      n_errors++;
      $display("FAIL bnd_second cycles=%0d hi=%0d exp=10/2 pdrop=%0d bad=%0d",
               cy, hi, pd, bad);
    end
    n_checks++;
    if (o_pending !== 1'b0) begin
      n_errors++;
      $display("FAIL bnd_clear pending=%b exp=0", o_pending);
    end
  endtask

  task automatic test_shrink();
    int bad, hi, ps, acks, enas, cy, pd;
    bad = 0;
    for (int k = 0; k < 20 && m_pos != 7; k++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0);
      note_bad(bad);
    end
    step(1'b1, 1'b1, 4'd2, 4'd3);
    run_to_ack(1, cy, bad, hi, pd);
    n_checks++;
    if (cy != 2 || bad != 0) begin
      n_errors++;
      $display("FAIL shrink_wrap cycles=%0d exp=2 bad=%0d", cy, bad);
    end
    run(8, 1, bad, hi, ps, acks, enas);
    n_checks++;
    if (ps != 2 || hi != 4 || o_period_start !== 1'b1 || bad != 0) begin
      n_errors++;
      $display("FAIL shrink_period ps=%0d hi=%0d exp=2/4 bad=%0d", ps, hi, bad);
    end
  endtask

  task automatic test_random();
    int bad;
    bit e, ld;
    logic [3:0] d, p;
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      e = ($urandom_range(0, 99) < 60);
      ld = ($urandom_range(0, 99) < 6);
      d = 4'($urandom_range(0, 15));
      p = 4'($urandom_range(0, 15));
      step(e, ld, d, p);
      n_checks++;
      if (got() !== expv()) begin
        n_errors++;
        if (bad < 5)
          $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got(), expv());
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_extremes();
    test_back_to_back();
    test_boundary_load();
    test_shrink();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
